// File: rtl/exe_issue_stage_pkg.sv
// rtl/exe_issue_stage_pkg.sv - shared instruction types, FSM states and decode helpers for the issue stage
package exe_issue_stage_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDU = 4'd1,
        OP_SUBU = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_LW   = 4'd5,
        OP_LBU  = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQZ = 4'd8
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
        logic [4:0] rs_imm;
    } instruction_s;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } exe_state_e;

    function automatic logic is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LBU);
    endfunction

    function automatic logic writes_reg(input op_e op);
        case (op)
            OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_LW, OP_LBU: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exe_issue_stage_fwd_mux.sv
// rtl/exe_issue_stage_fwd_mux.sv - one-operand priority forwarding mux used at issue capture
module exe_fwd_mux (
    input  logic [4:0]  src_idx,
    input  logic [31:0] dec_val,
    input  logic        s1_fwd_en,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_val,
    input  logic        s2_fwd_en,
    input  logic [4:0]  s2_rd,
    input  logic [31:0] s2_val,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] fwd_val
);

    // Youngest producer wins; r0 always reads as zero.
    always_comb begin
        fwd_val = dec_val;
        if (src_idx == 5'd0) begin
            fwd_val = 32'd0;
        end else if (s1_fwd_en && (s1_rd == src_idx)) begin
            fwd_val = s1_val;
        end else if (s2_fwd_en && (s2_rd == src_idx)) begin
            fwd_val = s2_val;
        end else if (wb_we && (wb_addr == src_idx)) begin
            fwd_val = wb_data;
        end
    end

endmodule

// File: rtl/exe_issue_stage.sv
// rtl/exe_issue_stage.sv - execute issue stage: S1/S2 registers, forwarding, load-use stall and branch squash
module exe_issue_stage
    import exe_issue_stage_pkg::*;
#(
    parameter int FLUSH_SLOTS = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         dec_valid_i,
    output logic         dec_ready_o,
    input  instruction_s dec_instr_i,
    input  logic [31:0]  dec_rd_val_i,
    input  logic [31:0]  dec_rs_val_i,
    output logic [31:0]  alu_rd_o,
    output logic [31:0]  alu_rs_o,
    output instruction_s alu_op_o,
    input  logic [31:0]  alu_result_i,
    input  logic         alu_jump_i,
    output logic         mem_valid_o,
    input  logic         mem_ready_i,
    output instruction_s mem_instr_o,
    output logic [31:0]  mem_result_o,
    input  logic         wb_we_i,
    input  logic [4:0]   wb_addr_i,
    input  logic [31:0]  wb_data_i,
    output logic         flush_o
);

    localparam int CNT_W = $clog2(FLUSH_SLOTS) + 1;

    logic         s1_valid_q, s1_valid_d;
    instruction_s s1_instr_q, s1_instr_d;
    logic [31:0]  s1_rd_val_q, s1_rd_val_d;
    logic [31:0]  s1_rs_val_q, s1_rs_val_d;
    logic         s2_valid_q, s2_valid_d;
    instruction_s s2_instr_q, s2_instr_d;
    logic [31:0]  s2_result_q, s2_result_d;
    exe_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        s2_free, s1_adv, s1_open, taken, squash, hazard, capture;
    logic        s1_load, s2_load, s1_fwd_en, s2_fwd_en;
    logic [31:0] fwd_rd, fwd_rs;

    assign s1_fwd_en = s1_valid_q && writes_reg(s1_instr_q.op) && !is_load(s1_instr_q.op);
    assign s2_fwd_en = s2_valid_q && writes_reg(s2_instr_q.op) && !is_load(s2_instr_q.op);

    exe_fwd_mux u_fwd_rd (
        .src_idx   (dec_instr_i.rd),
        .dec_val   (dec_rd_val_i),
        .s1_fwd_en (s1_fwd_en),
        .s1_rd     (s1_instr_q.rd),
        .s1_val    (alu_result_i),
        .s2_fwd_en (s2_fwd_en),
        .s2_rd     (s2_instr_q.rd),
        .s2_val    (s2_result_q),
        .wb_we     (wb_we_i),
        .wb_addr   (wb_addr_i),
        .wb_data   (wb_data_i),
        .fwd_val   (fwd_rd)
    );

    exe_fwd_mux u_fwd_rs (
        .src_idx   (dec_instr_i.rs_imm),
        .dec_val   (dec_rs_val_i),
        .s1_fwd_en (s1_fwd_en),
        .s1_rd     (s1_instr_q.rd),
        .s1_val    (alu_result_i),
        .s2_fwd_en (s2_fwd_en),
        .s2_rd     (s2_instr_q.rd),
        .s2_val    (s2_result_q),
        .wb_we     (wb_we_i),
        .wb_addr   (wb_addr_i),
        .wb_data   (wb_data_i),
        .fwd_val   (fwd_rs)
    );

    always_comb begin
        s2_free = !s2_valid_q || mem_ready_i;
        s1_adv  = s1_valid_q && s2_free;
        s1_open = !s1_valid_q || s1_adv;
        taken   = s1_adv && alu_jump_i;
        squash  = taken || (state_q == FLUSH);

        // Loads to r0 produce nothing worth waiting for.
        s1_load = s1_valid_q && is_load(s1_instr_q.op) && (s1_instr_q.rd != 5'd0);
        s2_load = s2_valid_q && is_load(s2_instr_q.op) && (s2_instr_q.rd != 5'd0);
        hazard  = dec_valid_i &&
                  ((s1_load && ((dec_instr_i.rd == s1_instr_q.rd) || (dec_instr_i.rs_imm == s1_instr_q.rd))) ||
                   (s2_load && ((dec_instr_i.rd == s2_instr_q.rd) || (dec_instr_i.rs_imm == s2_instr_q.rd))));

        dec_ready_o = n_reset && (squash || (s1_open && !hazard));
        capture     = dec_valid_i && dec_ready_o && !squash;
        flush_o     = taken;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN, STALL: begin
                if (taken) begin
                    if (FLUSH_SLOTS > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_SLOTS - 1);
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = hazard ? STALL : RUN;
                end
            end
            FLUSH: begin
                if (dec_valid_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_rd_val_d = s1_rd_val_q;
        s1_rs_val_d = s1_rs_val_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_result_d = s2_result_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (capture) begin
            s1_valid_d  = 1'b1;
            s1_instr_d  = dec_instr_i;
            s1_rd_val_d = fwd_rd;
            s1_rs_val_d = fwd_rs;
        end
        // S2 contents only change when it is free, so stalled outputs stay put.
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d  = s1_instr_q;
                s2_result_d = alu_result_i;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_rd_val_q <= 32'd0;
            s1_rs_val_q <= 32'd0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_result_q <= 32'd0;
            state_q     <= RUN;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_rd_val_q <= s1_rd_val_d;
            s1_rs_val_q <= s1_rs_val_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_result_q <= s2_result_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_rd_o     = s1_rd_val_q;
    assign alu_rs_o     = s1_rs_val_q;
    assign alu_op_o     = s1_valid_q ? s1_instr_q : '0;
    assign mem_valid_o  = s2_valid_q;
    assign mem_instr_o  = s2_instr_q;
    assign mem_result_o = s2_result_q;

endmodule

// File: tb/tb_exe_issue_stage.sv
// tb/tb_exe_issue_stage.sv - directed and randomized self-checking bench for exe_issue_stage
module tb_exe_issue_stage;
    import exe_issue_stage_pkg::*;

    localparam int FS = 2;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         dec_valid_i, dec_ready_o;
    instruction_s dec_instr_i, alu_op_o, mem_instr_o;
    logic [31:0]  dec_rd_val_i, dec_rs_val_i, alu_rd_o, alu_rs_o, alu_result_i, mem_result_o;
    logic         alu_jump_i, mem_valid_o, mem_ready_i, wb_we_i, flush_o;
    logic [4:0]   wb_addr_i;
    logic [31:0]  wb_data_i;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic         v;
        instruction_s ins;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  res;
    } slot_t;

    slot_t m1, m2;
    int    drops_left;

    exe_issue_stage #(.FLUSH_SLOTS(FS)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .dec_valid_i  (dec_valid_i),
        .dec_ready_o  (dec_ready_o),
        .dec_instr_i  (dec_instr_i),
        .dec_rd_val_i (dec_rd_val_i),
        .dec_rs_val_i (dec_rs_val_i),
        .alu_rd_o     (alu_rd_o),
        .alu_rs_o     (alu_rs_o),
        .alu_op_o     (alu_op_o),
        .alu_result_i (alu_result_i),
        .alu_jump_i   (alu_jump_i),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_instr_o  (mem_instr_o),
        .mem_result_o (mem_result_o),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .flush_o      (flush_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADDU, OP_LW, OP_LBU, OP_SW: return a + b;
            OP_SUBU:                       return a - b;
            OP_AND:                        return a & b;
            OP_OR:                         return a | b;
            default:                       return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result_i = alu_fn(alu_op_o.op, alu_rd_o, alu_rs_o);
        alu_jump_i   = (alu_op_o.op == OP_BEQZ) && (alu_rd_o == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value an instruction should see: youngest in-flight ALU producer, then writeback, then register file.
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf_val);
        slot_t producers [2];
        producers[0] = m1;
        producers[1] = m2;
        if (idx == 5'd0) return 32'd0;
        foreach (producers[i]) begin
            if (producers[i].v && writes_reg(producers[i].ins.op) && !is_load(producers[i].ins.op) &&
                producers[i].ins.rd == idx) return producers[i].res;
        end
        if (wb_we_i && wb_addr_i == idx) return wb_data_i;
        return rf_val;
    endfunction

    function automatic logic load_blocks(input slot_t s, input instruction_s in);
        return s.v && is_load(s.ins.op) && s.ins.rd != 5'd0 && (in.rd == s.ins.rd || in.rs_imm == s.ins.rd);
    endfunction

    task automatic model_reset();
        m1 = '0;
        m2 = '0;
        drops_left = 0;
    endtask

    task automatic offer(input logic v, input op_e op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [31:0] a, input logic [31:0] b);
        dec_valid_i        = v;
        dec_instr_i.op     = op;
        dec_instr_i.rd     = rd;
        dec_instr_i.rs_imm = rs;
        dec_rd_val_i       = a;
        dec_rs_val_i       = b;
    endtask

    task automatic idle();
        offer(1'b0, OP_NOP, 5'd0, 5'd0, 32'd0, 32'd0);
        wb_we_i = 1'b0;
    endtask

    // Check one cycle against the model, then advance the model and the clock (negedge to negedge).
    task automatic step();
        logic  jump, adv, exp_flush, hazard, squash, exp_ready;
        slot_t n1, n2;
        #1;
        jump      = m1.v && m1.ins.op == OP_BEQZ && m1.a == 32'd0;
        adv       = m1.v && (!m2.v || mem_ready_i);
        exp_flush = adv && jump;
        hazard    = dec_valid_i && (load_blocks(m1, dec_instr_i) || load_blocks(m2, dec_instr_i));
        squash    = exp_flush || drops_left > 0;
        exp_ready = squash || ((!m1.v || adv) && !hazard);
        chk("dec_ready", 32'(dec_ready_o), 32'(exp_ready));
        chk("flush", 32'(flush_o), 32'(exp_flush));
        chk("mem_valid", 32'(mem_valid_o), 32'(m2.v));
        if (m2.v) begin
            chk("mem_instr", 32'(mem_instr_o), 32'(m2.ins));
            chk("mem_result", mem_result_o, m2.res);
        end
        chk("alu_op", 32'(alu_op_o), m1.v ? 32'(m1.ins) : 32'd0);
        if (m1.v) begin
            chk("alu_rd", alu_rd_o, m1.a);
            chk("alu_rs", alu_rs_o, m1.b);
        end
        n1 = m1;
        n2 = m2;
        if (!m2.v || mem_ready_i) begin
            n2 = m1;
        end
        if (adv) n1.v = 1'b0;
        if (dec_valid_i && exp_ready && !squash) begin
            n1.v   = 1'b1;
            n1.ins = dec_instr_i;
            n1.a   = ref_operand(dec_instr_i.rd, dec_rd_val_i);
            n1.b   = ref_operand(dec_instr_i.rs_imm, dec_rs_val_i);
            n1.res = alu_fn(dec_instr_i.op, n1.a, n1.b);
        end
        if (exp_flush) drops_left = FS - 1;
        else if (drops_left > 0 && dec_valid_i) drops_left--;
        m1 = n1;
        m2 = n2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_step();
        op_e         op;
        logic [31:0] a;
        op = op_e'(4'($urandom_range(0, 8)));
        a  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        offer(($urandom_range(0, 4) != 0), op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a, $urandom);
        mem_ready_i = ($urandom_range(0, 3) != 0);
        wb_we_i     = $urandom_range(0, 1) == 1;
        wb_addr_i   = 5'($urandom_range(0, 7));
        wb_data_i   = $urandom;
        step();
    endtask

    initial begin
        n_reset     = 1'b0;
        mem_ready_i = 1'b1;
        wb_addr_i   = 5'd0;
        wb_data_i   = 32'd0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_dec_ready", 32'(dec_ready_o), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_mem_result", mem_result_o, 32'd0);
        chk("rst_mem_instr", 32'(mem_instr_o), 32'd0);
        chk("rst_alu_op", 32'(alu_op_o), 32'd0);
        n_reset = 1'b1;

        // back-to-back dependency through S1
        offer(1'b1, OP_ADDU, 5'd1, 5'd2, 32'd10, 32'd20);  step();
        offer(1'b1, OP_ADDU, 5'd1, 5'd3, 32'd99, 32'd5);   step();
        idle(); #1;
        chk("s1_forward", alu_rd_o, 32'd30);
        repeat (3) step();

        // load-use stall resolved by writeback
        offer(1'b1, OP_LW, 5'd3, 5'd4, 32'h100, 32'h4);    step();
        offer(1'b1, OP_ADDU, 5'd3, 5'd5, 32'h77, 32'h1);
        #1; chk("load_use_ready0", 32'(dec_ready_o), 32'd0); step();
        #1; chk("load_use_ready1", 32'(dec_ready_o), 32'd0); step();
        wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h55;
        step();
        idle(); #1;
        chk("load_use_wb", alu_rd_o, 32'h55);
        repeat (3) step();

        // taken branch squashes two transfers
        offer(1'b1, OP_BEQZ, 5'd6, 5'd0, 32'd0, 32'd0);     step();
        offer(1'b1, OP_ADDU, 5'd7, 5'd7, 32'd1, 32'd1);
        #1; chk("branch_flush", 32'(flush_o), 32'd1);       step();
        offer(1'b1, OP_ADDU, 5'd9, 5'd9, 32'd2, 32'd2);
        #1; chk("branch_flush_once", 32'(flush_o), 32'd0);  step();
        offer(1'b1, OP_ADDU, 5'd10, 5'd10, 32'd3, 32'd3);   step();
        idle(); step(); #1;
        chk("branch_third_valid", 32'(mem_valid_o), 32'd1);
        chk("branch_third_result", mem_result_o, 32'd6);
        repeat (2) step();

        // memory backpressure with both stages full
        mem_ready_i = 1'b0;
        offer(1'b1, OP_ADDU, 5'd11, 5'd12, 32'd5, 32'd6);   step();
        offer(1'b1, OP_ADDU, 5'd13, 5'd14, 32'd7, 32'd8);   step();
        offer(1'b1, OP_ADDU, 5'd15, 5'd16, 32'd1, 32'd1);
        repeat (3) step();
        #1;
        chk("bp_ready", 32'(dec_ready_o), 32'd0);
        chk("bp_hold", mem_result_o, 32'd11);
        mem_ready_i = 1'b1;
        step();
        idle();
        repeat (4) step();

        // S2 beats writeback; r0 always zero
        offer(1'b1, OP_ADDU, 5'd8, 5'd9, 32'h10, 32'h1);    step();
        offer(1'b1, OP_SW, 5'd10, 5'd11, 32'd0, 32'd0);     step();
        offer(1'b1, OP_ADDU, 5'd8, 5'd12, 32'h99, 32'h2);
        wb_we_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'h22;
        step();
        offer(1'b1, OP_ADDU, 5'd0, 5'd0, 32'h1234, 32'h5678);
        wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hdead;
        #1; chk("s2_over_wb", alu_rd_o, 32'h11);
        step();
        idle(); #1;
        chk("r0_rd_zero", alu_rd_o, 32'd0);
        chk("r0_rs_zero", alu_rs_o, 32'd0);
        repeat (3) step();

        repeat (400) rand_step();

        // reset with both stages occupied
        mem_ready_i = 1'b0;
        offer(1'b1, OP_ADDU, 5'd1, 5'd2, 32'd3, 32'd4);     step();
        offer(1'b1, OP_BEQZ, 5'd2, 5'd0, 32'd0, 32'd0);     step();
        #1;
        chk("pre_rst_mem_valid", 32'(mem_valid_o), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_mem_valid", 32'(mem_valid_o), 32'd0);
        chk("mid_rst_flush", 32'(flush_o), 32'd0);
        chk("mid_rst_ready", 32'(dec_ready_o), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op_o), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_reset     = 1'b1;
        mem_ready_i = 1'b1;
        offer(1'b1, OP_OR, 5'd4, 5'd5, 32'hf0, 32'h0f);     step();
        idle();
        repeat (3) step();
        repeat (60) rand_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
